usb_tx_serializer: RTL



---
 rtl/usb_tx_pkg.sv | 30 +++
 rtl/usb_tx_bit_timer.sv | 35 +++
 rtl/usb_tx_serializer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkg                                                           |
// | Shared types and line constants for the USB full-speed transmitter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         EOP_SE0_BITS = 2;

  // Line states as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    return bit_val ? line : ((line == LINE_J) ? LINE_K : LINE_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_bit_timer                                                     |
// | Bit-period counter producing a one-clock tick every CLKS_PER_BIT.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic bit_tick
);

  localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  assign bit_tick = en & (r_cnt == c_CNT_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= bit_tick ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_serializer                                                    |
// | Byte-to-line USB FS transmitter: SYNC, bit stuffing, NRZI and EOP.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       d_plus,
  output logic       d_minus
);

  localparam logic [2:0] c_STUFF_MAX = 3'(STUFF_LIMIT);
  localparam logic [1:0] c_SE0_LAST  = 2'(EOP_SE0_BITS - 1);

  tx_state_e  r_state;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_hold_last;
  logic [7:0] r_shift;
  logic [2:0] r_bits_left;
  logic       r_cur_last;
  logic [2:0] r_ones;
  logic [1:0] r_eop_cnt;
  logic       r_last_acc;
  logic [1:0] r_line;
  logic       r_error;

  logic w_tick;
  logic w_accept;
  logic w_start;

  function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic bit_val);
    if (!bit_val) return 3'd0;
    return (ones == c_STUFF_MAX) ? ones : ones + 3'd1;
  endfunction

  assign tx_ready = ~r_hold_full & ~r_last_acc & (r_state inside {IDLE, SYNC, DATA});
  assign tx_busy  = (r_state != IDLE);
  assign tx_error = r_error;
  assign d_plus   = r_line[1];
  assign d_minus  = r_line[0];

  assign w_accept = tx_valid & tx_ready;
  // A byte left in holding by an accept racing an underrun starts the next packet.
  assign w_start  = (r_state == IDLE) & (w_accept | r_hold_full);

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (r_state != IDLE),
    .clr      (w_start),
    .bit_tick (w_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_cur_last  <= 1'b0;
      r_ones      <= '0;
      r_eop_cnt   <= '0;
      r_last_acc  <= 1'b0;
      r_line      <= LINE_J;
      r_error     <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
        r_hold_last <= tx_last;
        if (tx_last) r_last_acc <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= SYNC;
            r_line      <= nrzi_next(r_line, SYNC_BYTE[0]);
            r_ones      <= ones_next(3'd0, SYNC_BYTE[0]);
            r_shift     <= SYNC_BYTE >> 1;
            r_bits_left <= 3'd7;
            r_cur_last  <= 1'b0;
          end
        end
        SYNC, DATA: begin
          if (w_tick) begin
            if (r_ones == c_STUFF_MAX) begin
              r_line <= nrzi_next(r_line, 1'b0);
              r_ones <= 3'd0;
            end else if (r_bits_left != 3'd0) begin
              r_line      <= nrzi_next(r_line, r_shift[0]);
              r_ones      <= ones_next(r_ones, r_shift[0]);
              r_shift     <= r_shift >> 1;
              r_bits_left <= r_bits_left - 3'd1;
            end else if (r_cur_last) begin
              r_state   <= EOP_SE0;
              r_line    <= LINE_SE0;
              r_eop_cnt <= '0;
            end else if (r_hold_full) begin
              r_state     <= DATA;
              r_line      <= nrzi_next(r_line, r_hold[0]);
              r_ones      <= ones_next(r_ones, r_hold[0]);
              r_shift     <= r_hold >> 1;
              r_bits_left <= 3'd7;
              r_cur_last  <= r_hold_last;
              r_hold_full <= 1'b0;
            end else begin
              r_error   <= 1'b1;
              r_state   <= EOP_SE0;
              r_line    <= LINE_SE0;
              r_eop_cnt <= '0;
            end
          end
        end
        EOP_SE0: begin
          if (w_tick) begin
            if (r_eop_cnt == c_SE0_LAST) begin
              r_state <= EOP_J;
              r_line  <= LINE_J;
            end else begin
              r_eop_cnt <= r_eop_cnt + 2'd1;
            end
          end
        end
        EOP_J: begin
          if (w_tick) begin
            r_state    <= IDLE;
            r_ones     <= 3'd0;
            r_last_acc <= r_hold_full & r_hold_last;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
